// File: rtl/source_arbiter.sv
// -----------------------------------------------------------------------------
// source_arbiter
//
// Round-robin arbiter that hands a single downstream port to one of three
// byte-wide sources (alpha, beta, gamma). A source holds the grant until it
// drops its request or has moved QUOTA beats, after which the arbiter always
// spends exactly one cycle idle before it grants again.
//
// Parameters
//   QUOTA      maximum beats per grant (1..8)
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   req[2:0]   per-source request (bit0 alpha, bit1 beta, bit2 gamma)
//   alpha      source 0 data
//   beta       source 1 data
//   gamma      source 2 data
//   out_ready  downstream accepts a beat this cycle
//   sel[1:0]   registered source select (00 alpha, 01 beta, 10 gamma)
//   cs         registered chip select, high while a grant is held
//   grant[2:0] registered one-hot grant, zero while idle
//   out_valid  cs && req[sel]
//   out[7:0]   data of the selected source, 8'h00 while idle
// -----------------------------------------------------------------------------
module source_arbiter #(
    parameter int QUOTA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] alpha,
    input  logic [7:0] beta,
    input  logic [7:0] gamma,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       cs,
    output logic [2:0] grant,
    output logic       out_valid,
    output logic [7:0] out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Count value of the final beat a grant may carry.
    localparam logic [2:0] LAST_BEAT = 3'(QUOTA - 1);

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_sel;
    logic [1:0] w_selNext;
    logic [1:0] r_last;
    logic [1:0] w_lastNext;
    logic [2:0] r_count;
    logic [2:0] w_countNext;
    logic [2:0] r_grant;
    logic [2:0] w_grantNext;
    logic [1:0] w_pick;
    logic       w_reqSel;
    logic       w_beat;

    // Request bit of the currently selected source. Written as a case so the
    // unused select code 11 reads as "not requesting" instead of indexing
    // past the end of req.
    always_comb begin
        w_reqSel = 1'b0;
        case (r_sel)
            2'd0:    w_reqSel = req[0];
            2'd1:    w_reqSel = req[1];
            2'd2:    w_reqSel = req[2];
            default: w_reqSel = 1'b0;
        endcase
    end

    // Round-robin choice: search starting at the source after the one that
    // was served last, wrapping modulo 3. Only meaningful when req != 0.
    always_comb begin
        w_pick = 2'd0;
        case (r_last)
            2'd0: begin
                if (req[1])      w_pick = 2'd1;
                else if (req[2]) w_pick = 2'd2;
                else             w_pick = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_pick = 2'd2;
                else if (req[0]) w_pick = 2'd0;
                else             w_pick = 2'd1;
            end
            default: begin
                if (req[0])      w_pick = 2'd0;
                else if (req[1]) w_pick = 2'd1;
                else             w_pick = 2'd2;
            end
        endcase
    end

    // Output side: cs is simply the state flop, out_valid and out follow the
    // live request and data of the selected source.
    assign cs        = (r_state == GRANT);
    assign out_valid = cs && w_reqSel;
    assign w_beat    = out_valid && out_ready;
    assign sel       = r_sel;
    assign grant     = r_grant;

    always_comb begin
        out = 8'h00;
        if (cs) begin
            case (r_sel)
                2'd0:    out = alpha;
                2'd1:    out = beta;
                2'd2:    out = gamma;
                default: out = 8'h00;
            endcase
        end
    end

    // Next-state logic. A release always lands in IDLE, and IDLE is the only
    // state that can grant, which guarantees one idle cycle between grants.
    // While granted, sel is frozen; other request bits are ignored.
    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        w_lastNext  = r_last;
        w_countNext = r_count;
        case (r_state)
            IDLE: begin
                if (req != 3'b000) begin
                    w_stateNext = GRANT;
                    w_selNext   = w_pick;
                    w_countNext = 3'd0;
                end
            end
            GRANT: begin
                if (!w_reqSel) begin
                    w_stateNext = IDLE;
                    w_lastNext  = r_sel;
                    w_countNext = 3'd0;
                end else if (w_beat) begin
                    if (r_count == LAST_BEAT) begin
                        w_stateNext = IDLE;
                        w_lastNext  = r_sel;
                        w_countNext = 3'd0;
                    end else begin
                        w_countNext = r_count + 3'd1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_countNext = 3'd0;
            end
        endcase
        w_grantNext = (w_stateNext == GRANT) ? (3'b001 << w_selNext) : 3'b000;
    end

    // State registers. Reset wins over everything, including a beat that is
    // in flight, and leaves alpha as the first choice (last = gamma).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_last  <= 2'd2;
            r_count <= 3'd0;
            r_grant <= 3'b000;
        end else begin
            r_state <= w_stateNext;
            r_sel   <= w_selNext;
            r_last  <= w_lastNext;
            r_count <= w_countNext;
            r_grant <= w_grantNext;
        end
    end

endmodule

// File: tb/tb_source_arbiter.sv
// -----------------------------------------------------------------------------
// tb_source_arbiter
//
// Self-checking bench for source_arbiter. Two instances share all inputs:
// the main one with QUOTA=4 and a second with QUOTA=1. Every step drives the
// inputs, pushes the hand-derived expected outputs onto a scoreboard queue,
// waits one rising edge and then pops and compares. A table of vectors covers
// the main round-robin / quota / stall / release / reset behaviour; short
// hand-written sequences cover the long idle run, the long stall and QUOTA=1.
// -----------------------------------------------------------------------------
module tb_source_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [7:0] alpha;
    logic [7:0] beta;
    logic [7:0] gamma;
    logic       outReady;

    logic [1:0] sel;
    logic       cs;
    logic [2:0] grant;
    logic       outValid;
    logic [7:0] outData;

    logic [1:0] q1Sel;
    logic       q1Cs;
    logic [2:0] q1Grant;
    logic       q1Valid;
    logic [7:0] q1Out;

    // 100 MHz clock.
    always #5 clk = ~clk;

    source_arbiter #(.QUOTA(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .alpha     (alpha),
        .beta      (beta),
        .gamma     (gamma),
        .out_ready (outReady),
        .sel       (sel),
        .cs        (cs),
        .grant     (grant),
        .out_valid (outValid),
        .out       (outData)
    );

    source_arbiter #(.QUOTA(1)) dutQ1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .alpha     (alpha),
        .beta      (beta),
        .gamma     (gamma),
        .out_ready (outReady),
        .sel       (q1Sel),
        .cs        (q1Cs),
        .grant     (q1Grant),
        .out_valid (q1Valid),
        .out       (q1Out)
    );

    typedef struct {
        bit         rst;
        logic [2:0] req;
        bit         rdy;
        bit         cs;
        logic [1:0] sel;
        logic [2:0] grant;
        bit         valid;
        logic [7:0] out;
    } vec_t;

    typedef struct {
        bit          which;
        int          tag;
        logic [14:0] exp;
    } expect_t;

    expect_t sbQueue[$];
    int      checks = 0;
    int      errors = 0;

    // Drive one set of inputs and record what the chosen instance must show
    // after the next rising edge.
    task automatic applyStimulus(input bit rst, input logic [2:0] r, input bit rdy,
                                 input bit which, input int tag,
                                 input bit eCs, input logic [1:0] eSel,
                                 input logic [2:0] eGrant, input bit eValid,
                                 input logic [7:0] eOut);
        expect_t e;
        reset    = rst;
        req      = r;
        outReady = rdy;
        e.which  = which;
        e.tag    = tag;
        e.exp    = {eCs, eSel, eGrant, eValid, eOut};
        sbQueue.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the selected instance.
    task automatic checkOutput();
        expect_t     e;
        logic [14:0] act;
        checks++;
        if (sbQueue.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: output observed with no expected entry queued");
            return;
        end
        e   = sbQueue.pop_front();
        act = e.which ? {q1Cs, q1Sel, q1Grant, q1Valid, q1Out}
                      : {cs, sel, grant, outValid, outData};
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got cs=%0b sel=%0d grant=%03b valid=%0b out=%02h, expected cs=%0b sel=%0d grant=%03b valid=%0b out=%02h",
                     e.which ? "quota1" : "main", e.tag,
                     act[14], act[13:12], act[11:9], act[8], act[7:0],
                     e.exp[14], e.exp[13:12], e.exp[11:9], e.exp[8], e.exp[7:0]);
        end
    endtask

    task automatic step(input bit rst, input logic [2:0] r, input bit rdy,
                        input bit which, input int tag,
                        input bit eCs, input logic [1:0] eSel,
                        input logic [2:0] eGrant, input bit eValid,
                        input logic [7:0] eOut);
        applyStimulus(rst, r, rdy, which, tag, eCs, eSel, eGrant, eValid, eOut);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [26];
        logic [7:0] g;
        int         tag;

        reset    = 1'b1;
        req      = 3'b000;
        outReady = 1'b0;
        alpha    = 8'hA1;
        beta     = 8'hB2;
        gamma    = 8'hC3;

        //           rst   req     rdy   cs    sel   grant   vld   out
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};
        vecs[3]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};
        vecs[4]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};
        vecs[5]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};
        vecs[6]  = '{1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[8]  = '{1'b0, 3'b110, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[9]  = '{1'b0, 3'b010, 1'b0, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[10] = '{1'b0, 3'b010, 1'b0, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[11] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[12] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[13] = '{1'b0, 3'b010, 1'b1, 1'b0, 2'd1, 3'b000, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 3'b100, 1'b0, 1'b1, 2'd2, 3'b100, 1'b1, 8'hC3};
        vecs[15] = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1, 8'hC3};
        vecs[16] = '{1'b0, 3'b100, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1, 8'hC3};
        vecs[17] = '{1'b0, 3'b011, 1'b1, 1'b0, 2'd2, 3'b000, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 3'b011, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};
        vecs[19] = '{1'b0, 3'b010, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[20] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[21] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[22] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2};
        vecs[23] = '{1'b1, 3'b010, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[24] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00};
        vecs[25] = '{1'b0, 3'b101, 1'b0, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1};

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].rdy, 1'b0, i,
                 vecs[i].cs, vecs[i].sel, vecs[i].grant, vecs[i].valid, vecs[i].out);
        end
        tag = 100;

        // Alpha drops its request, then twenty quiet cycles with noisy data.
        $display("[TB] long idle run");
        step(1'b0, 3'b000, 1'b0, 1'b0, tag, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);
        tag++;
        for (int i = 0; i < 20; i++) begin
            alpha = 8'($urandom);
            beta  = 8'($urandom);
            gamma = 8'($urandom);
            step(1'b0, 3'b000, 1'b0, 1'b0, tag, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);
            tag++;
        end

        // Beta alone, held off by out_ready for ten cycles, then four beats.
        $display("[TB] long stall on beta");
        beta = 8'h5B;
        step(1'b0, 3'b010, 1'b0, 1'b0, tag, 1'b1, 2'd1, 3'b010, 1'b1, 8'h5B);
        tag++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'b010, 1'b0, 1'b0, tag, 1'b1, 2'd1, 3'b010, 1'b1, 8'h5B);
            tag++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b010, 1'b1, 1'b0, tag, 1'b1, 2'd1, 3'b010, 1'b1, 8'h5B);
            tag++;
        end
        step(1'b0, 3'b010, 1'b1, 1'b0, tag, 1'b0, 2'd1, 3'b000, 1'b0, 8'h00);
        tag++;
        g     = 8'($urandom);
        gamma = g;
        step(1'b0, 3'b111, 1'b1, 1'b0, tag, 1'b1, 2'd2, 3'b100, 1'b1, g);
        tag++;

        // QUOTA=1 instance: one beat per grant, one idle cycle between.
        $display("[TB] single-beat quota");
        alpha = 8'hA1;
        beta  = 8'hB2;
        gamma = 8'hC3;
        tag   = 200;
        step(1'b1, 3'b111, 1'b1, 1'b1, tag, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b1, 2'd1, 3'b010, 1'b1, 8'hB2); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b0, 2'd1, 3'b000, 1'b0, 8'h00); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b1, 2'd2, 3'b100, 1'b1, 8'hC3); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b0, 2'd2, 3'b000, 1'b0, 8'h00); tag++;
        step(1'b0, 3'b111, 1'b1, 1'b1, tag, 1'b1, 2'd0, 3'b001, 1'b1, 8'hA1); tag++;

        if (sbQueue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard-drain: %0d entries left, expected 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
